// File: rtl/ym_bus_master.sv
// ym_bus_master
// Queued bus initiator for the CPU-side port of the YM2203 wrapper. A non-CPU
// host pushes register writes/reads into a small FIFO. Each request is played
// out as an address phase (A0=0) and a data phase (A0=1), both aligned to
// CE_CPU, followed by a programmable settle gap.
//
// Parameters
//   DEPTH    request FIFO depth (power of 2, >= 2)
//   WAIT_CE  CE_CPU ticks spent in HOLD after each data phase (0..255)
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   CE_CPU              chip clock enable; all chip-side updates happen on CE edges
//   REQ_VALID/REQ_READY request handshake (REQ_READY is combinational)
//   REQ_WR/REQ_REG/REQ_DATA  request payload (1 = write, 0 = read)
//   YM_A0/YM_WE/YM_DI   registered drive to the chip
//   YM_DO               chip read-back data
//   RD_DATA/RD_VALID    last read result and its one-cycle strobe
//   BUSY                FIFO non-empty or a transaction in progress
module ym_bus_master #(
    parameter int DEPTH   = 4,
    parameter int WAIT_CE = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE_CPU,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WR,
    input  logic [7:0] REQ_REG,
    input  logic [7:0] REQ_DATA,
    output logic       YM_A0,
    output logic       YM_WE,
    output logic [7:0] YM_DI,
    input  logic [7:0] YM_DO,
    output logic [7:0] RD_DATA,
    output logic       RD_VALID,
    output logic       BUSY
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    // FIFO storage: {wr, reg, data}
    logic [16:0] mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [16:0] head_s;

    state_t      state_r;
    state_t      state_s;
    logic        a0_r,  a0_s;
    logic        we_r,  we_s;
    logic [7:0]  di_r,  di_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        work_wr_r,   work_wr_s;
    logic [7:0]  work_data_r, work_data_s;
    logic [7:0]  rd_data_r,   rd_data_s;
    logic        rd_valid_r,  rd_valid_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

    assign REQ_READY = !full_s && !RESET;
    assign push_s    = REQ_VALID && REQ_READY;
    assign BUSY      = !RESET && (!empty_s || (state_r != IDLE));

    assign YM_A0    = a0_r;
    assign YM_WE    = we_r;
    assign YM_DI    = di_r;
    assign RD_DATA  = rd_data_r;
    assign RD_VALID = rd_valid_r;

    // Next-state and next-output logic; nothing moves unless CE_CPU is high.
    always_comb begin
        state_s     = state_r;
        a0_s        = a0_r;
        we_s        = we_r;
        di_s        = di_r;
        cnt_s       = cnt_r;
        work_wr_s   = work_wr_r;
        work_data_s = work_data_r;
        rd_data_s   = rd_data_r;
        rd_valid_s  = 1'b0;
        pop_s       = 1'b0;
        if (CE_CPU) begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        state_s     = ADDR;
                        pop_s       = 1'b1;
                        work_wr_s   = head_s[16];
                        work_data_s = head_s[7:0];
                        a0_s        = 1'b0;
                        we_s        = 1'b1;
                        di_s        = head_s[15:8];
                    end else begin
                        we_s = 1'b0;
                    end
                end
                ADDR: begin
                    state_s = DATA;
                    a0_s    = 1'b1;
                    if (work_wr_r) begin
                        we_s = 1'b1;
                        di_s = work_data_r;
                    end else begin
                        // Read: DI keeps the register number.
                        we_s = 1'b0;
                    end
                end
                DATA: begin
                    a0_s = 1'b0;
                    we_s = 1'b0;
                    if (!work_wr_r) begin
                        rd_data_s  = YM_DO;
                        rd_valid_s = 1'b1;
                    end else begin
                        rd_valid_s = 1'b0;
                    end
                    if (WAIT_INIT == 8'd0) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                        cnt_s   = WAIT_INIT;
                    end
                end
                HOLD: begin
                    cnt_s = cnt_r - 8'd1;
                    if (cnt_r <= 8'd1) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    a0_s    = 1'b0;
                    we_s    = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, output and pointer registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            a0_r        <= 1'b0;
            we_r        <= 1'b0;
            di_r        <= 8'h00;
            cnt_r       <= 8'h00;
            work_wr_r   <= 1'b0;
            work_data_r <= 8'h00;
            rd_data_r   <= 8'h00;
            rd_valid_r  <= 1'b0;
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
        end else begin
            state_r     <= state_s;
            a0_r        <= a0_s;
            we_r        <= we_s;
            di_r        <= di_s;
            cnt_r       <= cnt_s;
            work_wr_r   <= work_wr_s;
            work_data_r <= work_data_s;
            rd_data_r   <= rd_data_s;
            rd_valid_r  <= rd_valid_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage write; push is already blocked during reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {REQ_WR, REQ_REG, REQ_DATA};
        end
    end

endmodule

// File: tb/tb_ym_bus_master.sv
// Self-checking bench for ym_bus_master. A chip model samples A0/WE/DI on
// CE edges; requests pushed by the host are queued as expectations and
// compared when the corresponding address/data phases appear. A second
// instance with WAIT_CE=0 checks the no-HOLD launch spacing.
module tb_ym_bus_master;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE_CPU = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic       REQ_WR = 1'b0;
    logic [7:0] REQ_REG = 8'h00;
    logic [7:0] REQ_DATA = 8'h00;
    logic       YM_A0;
    logic       YM_WE;
    logic [7:0] YM_DI;
    logic [7:0] YM_DO;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic       BUSY;

    // second instance (WAIT_CE = 0)
    logic       req_valid2 = 1'b0;
    logic       req_ready2;
    logic [7:0] req_reg2 = 8'h00;
    logic       a0_2, we_2, rd_valid2, busy2;
    logic [7:0] di_2, rd_data2;
    logic [7:0] ym_do2 = 8'h00;

    typedef struct packed {
        logic       wr;
        logic [7:0] r;
        logic [7:0] d;
    } req_t;

    req_t       exp_q[$];
    logic [7:0] rd_q[$];

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         launch_cnt = 0;
    int         rd_cnt = 0;
    int         gap_last = -1;
    bit         gap_on = 1'b0;
    int         l2_last = 0;
    int         l2_cnt = 0;
    int         ce_mode = 0;     // 0 always high, 1 every 4th CLK, 2 held low
    logic [1:0] ce_ctr = 2'd0;
    logic       rv_prev = 1'b0;
    logic [7:0] chip_addr = 8'h00;

    // chip model: read data depends on the latched register number
    assign YM_DO = YM_A0 ? (chip_addr ^ 8'h38) : 8'h00;

    ym_bus_master #(.DEPTH(4), .WAIT_CE(2)) dut (
        .CLK(CLK), .RESET(RESET), .CE_CPU(CE_CPU),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
        .REQ_REG(REQ_REG), .REQ_DATA(REQ_DATA),
        .YM_A0(YM_A0), .YM_WE(YM_WE), .YM_DI(YM_DI), .YM_DO(YM_DO),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY)
    );

    ym_bus_master #(.DEPTH(4), .WAIT_CE(0)) dut_w0 (
        .CLK(CLK), .RESET(RESET), .CE_CPU(CE_CPU),
        .REQ_VALID(req_valid2), .REQ_READY(req_ready2), .REQ_WR(1'b1),
        .REQ_REG(req_reg2), .REQ_DATA(8'hA5),
        .YM_A0(a0_2), .YM_WE(we_2), .YM_DI(di_2), .YM_DO(ym_do2),
        .RD_DATA(rd_data2), .RD_VALID(rd_valid2), .BUSY(busy2)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic wr, input logic [7:0] r, input logic [7:0] d, output logic ok);
        req_t e;
        ok        = 1'b0;
        REQ_VALID = 1'b1;
        REQ_WR    = wr;
        REQ_REG   = r;
        REQ_DATA  = d;
        for (int i = 0; i < 64; i++) begin
            if (REQ_READY === 1'b1) begin
                e.wr = wr; e.r = r; e.d = d;
                exp_q.push_back(e);
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        REQ_VALID = 1'b0;
        if (!ok) $display("FAIL push_timeout: got not-ready expected ready");
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (BUSY === 1'b0) break;
            step();
        end
        check_eq("idle_reached", 32'(BUSY), 32'd0);
    endtask

    task automatic wait_launch(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            step();
            if (YM_WE === 1'b1 && YM_A0 === 1'b0) break;
        end
        check_eq("launch_seen", 32'({YM_WE, YM_A0}), 32'd2);
    endtask

    // CE generation and chip-side monitor, evaluated mid-cycle
    always @(negedge CLK) begin
        req_t e;
        cyc++;
        ce_ctr = ce_ctr + 2'd1;
        case (ce_mode)
            0:       CE_CPU = 1'b1;
            1:       CE_CPU = (ce_ctr == 2'd3);
            default: CE_CPU = 1'b0;
        endcase
        if (RD_VALID === 1'b1) begin
            rd_cnt++;
            check_eq("rd_single", 32'(rv_prev), 32'd0);
            check_eq("rd_expected", rd_q.size(), 32'd1);
            if (rd_q.size() != 0) check_eq("rd_data", 32'(RD_DATA), 32'(rd_q.pop_front()));
        end
        rv_prev = RD_VALID;
        if (CE_CPU) begin
            if (YM_WE === 1'b1 && YM_A0 === 1'b0) begin
                launch_cnt++;
                check_eq("addr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("addr_reg", 32'(YM_DI), 32'(exp_q[0].r));
                chip_addr = YM_DI;
                if (gap_on) begin
                    if (gap_last >= 0) check_eq("launch_gap", cyc - gap_last, 32'd5);
                    gap_last = cyc;
                end
            end else if (YM_A0 === 1'b1) begin
                check_eq("data_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("data_we", 32'(YM_WE), 32'(e.wr));
                    if (e.wr) begin
                        check_eq("data_di", 32'(YM_DI), 32'(e.d));
                    end else begin
                        check_eq("read_di", 32'(YM_DI), 32'(e.r));
                        rd_q.push_back(e.r ^ 8'h38);
                    end
                end
            end
            if (we_2 === 1'b1 && a0_2 === 1'b0) begin
                if (l2_cnt > 0) check_eq("w0_gap", cyc - l2_last, 32'd3);
                l2_last = cyc;
                l2_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   n;
        int   lc0;
        int   rc0;
        int   bad;

        // reset values
        repeat (3) step();
        check_eq("rst_ready", 32'(REQ_READY), 32'd0);
        check_eq("rst_busy",  32'(BUSY),      32'd0);
        check_eq("rst_a0we",  32'({YM_A0, YM_WE}), 32'd0);
        check_eq("rst_di",    32'(YM_DI),     32'd0);
        check_eq("rst_rd",    32'({RD_VALID, RD_DATA}), 32'd0);
        RESET = 1'b0;
        step();
        check_eq("ready_after_rst", 32'(REQ_READY), 32'd1);

        // single write, CE every 4th CLK
        ce_mode = 1;
        push(1'b1, 8'h28, 8'hF0, ok);
        wait_launch(40);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            if (CE_CPU) n++;
            #1;
            if (BUSY === 1'b0) break;
        end
        check_eq("busy_fall_ce", n, 32'd4);
        check_eq("we_after", 32'(YM_WE), 32'd0);
        check_eq("wr_done", exp_q.size(), 32'd0);

        // single read
        rc0 = rd_cnt;
        push(1'b0, 8'h07, 8'h00, ok);
        wait_idle(100);
        repeat (2) step();
        check_eq("rd_count", rd_cnt - rc0, 32'd1);
        check_eq("rd_final", 32'(RD_DATA), 32'h3F);
        check_eq("rd_q_empty", rd_q.size(), 32'd0);

        // back-to-back: fill with CE held low, then run CE constant-high
        ce_mode = 2;
        step();
        lc0 = launch_cnt;
        for (int i = 0; i < 4; i++) push((i != 2), 8'(8'h40 + i), 8'(8'h80 + i), ok);
        check_eq("full_ready", 32'(REQ_READY), 32'd0);
        check_eq("full_busy", 32'(BUSY), 32'd1);
        gap_last = -1;
        gap_on   = 1'b1;
        ce_mode  = 0;
        push(1'b1, 8'h44, 8'h84, ok);
        check_eq("ready_recover5", 32'(ok), 32'd1);
        push(1'b0, 8'h45, 8'h85, ok);
        check_eq("ready_recover6", 32'(ok), 32'd1);
        wait_idle(200);
        repeat (2) step();
        gap_on = 1'b0;
        check_eq("b2b_launches", launch_cnt - lc0, 32'd6);
        check_eq("b2b_drained", exp_q.size(), 32'd0);

        // WAIT_CE = 0 instance: two queued writes
        req_valid2 = 1'b1;
        req_reg2   = 8'h11;
        step();
        req_reg2   = 8'h12;
        step();
        req_valid2 = 1'b0;
        repeat (20) step();
        check_eq("w0_launches", l2_cnt, 32'd2);
        check_eq("w0_idle", 32'(busy2), 32'd0);

        // CE gated low for 20 CLK in the address phase
        push(1'b1, 8'h30, 8'h5A, ok);
        wait_launch(20);
        ce_mode = 2;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({YM_A0, YM_WE, YM_DI} !== {1'b0, 1'b1, 8'h30}) bad++;
        end
        check_eq("gate_hold", bad, 32'd0);
        check_eq("gate_busy", 32'(BUSY), 32'd1);
        ce_mode = 0;
        wait_idle(50);
        check_eq("gate_done", exp_q.size(), 32'd0);

        // reset during the data phase of a write with two entries queued
        ce_mode = 2;
        step();
        for (int i = 0; i < 3; i++) push(1'b1, 8'(8'h50 + i), 8'(8'h60 + i), ok);
        ce_mode = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (YM_A0 === 1'b1 && YM_WE === 1'b1) break;
        end
        check_eq("in_data", 32'({YM_A0, YM_WE}), 32'd3);
        RESET = 1'b1;
        step();
        check_eq("rst_we_now", 32'(YM_WE), 32'd0);
        check_eq("rst_busy_now", 32'(BUSY), 32'd0);
        check_eq("rst_ready_now", 32'(REQ_READY), 32'd0);
        exp_q.delete();
        step();
        RESET = 1'b0;
        lc0 = launch_cnt;
        repeat (20) step();
        check_eq("no_traffic", launch_cnt - lc0, 32'd0);
        check_eq("post_rst_busy", 32'(BUSY), 32'd0);
        check_eq("post_rst_we", 32'(YM_WE), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
